work_loader: RTL
================

# work_loader

Receives mining work over an 8-bit byte stream (UART receiver output), frames and checksums it, and presents a 256-bit midstate plus the 96-bit data tail to the mining core. A one-cycle `work_valid` strobe tells the core to latch the new work and restart its nonce counter. Malformed or stalled frames are discarded, and the previous work stays on the outputs.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: idle gap in cycles, between bytes of a partial frame, that aborts the frame.
- `HEADER`, default 8'h55: frame start byte.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid. There is no backpressure, so every strobe is consumed.
- `midstate`  out  256  last accepted midstate.
- `data`  out  96  last accepted data tail (the core's low 96 data bits).
- `work_valid`  out  1  one-cycle pulse when `midstate`/`data` update.
- `frame_err`  out  1  one-cycle pulse on checksum mismatch or timeout.

## Operation
- Frame format: `HEADER`, then 44 payload bytes, then 1 checksum byte.
  - Payload byte 0 goes to `midstate[255:248]`, byte 31 to `midstate[7:0]`, byte 32 to `data[95:88]`, byte 43 to `data[7:0]` (MSB first).
  - Checksum = XOR of the 44 payload bytes.
- FSM states:
  - IDLE: wait for a byte equal to `HEADER`. Any other byte is ignored, with no error.
  - PAYLOAD: shift each byte into a 352-bit shadow register, update the running XOR, and increment a 6-bit byte counter. After byte 43 is accepted, go to CHECK.
  - CHECK: on the next byte, compare it with the running XOR.
    - Match: copy shadow to `midstate`/`data`, pulse `work_valid`.
    - Mismatch: pulse `frame_err`; outputs are unchanged.
    - Either way, return to IDLE and clear the counter and XOR.
- In PAYLOAD and CHECK, a `HEADER` value is treated as ordinary data; there is no resync inside a frame.
- Timeout: a gap counter runs in PAYLOAD and CHECK.
  - It clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES` with no byte, the FSM goes to IDLE, clears the counter and XOR, and pulses `frame_err`.
  - A byte arriving in the cycle the timeout would fire is accepted and the timeout does not fire.
- Gap counter is 32 bits and saturates; it does not count in IDLE.
- Output registers change only on a good frame. The shadow register is never visible on the outputs.

## Timing
- Reset values: `midstate`=0, `data`=0, `work_valid`=0, `frame_err`=0. State is IDLE; byte counter, XOR and gap counter are 0.
- Reset has priority over every other event, including `rx_valid` in the same cycle. Reset mid-frame discards the partial frame with no `frame_err`.
- Latency: checksum byte is sampled at edge N. At that same edge N, `midstate`, `data` and `work_valid`=1 become visible; `work_valid` drops at N+1.
- `frame_err` has the same one-edge latency from the checksum byte or from the timeout condition.
- `work_valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames: a `HEADER` byte in the cycle right after the checksum byte starts a new frame. There is no dead cycle.
- Minimum frame is 46 accepted bytes. `rx_valid` may be high on consecutive cycles.

## Test plan
- **Good frame.** Send 0x55, payload 22 8e a4 73 2a 3c 9b a8 60 c0 09 cd a7 25 2b 91 61 a5 e7 5e c8 c5 82 a5 f1 06 ab b3 af 41 f7 90 21 94 26 1a 93 95 e6 4d be d1 71 15, checksum 0x1C.
  - Expect `midstate`=256'h228ea4732a3c9ba860c009cda7252b9161a5e75ec8c582a5f106abb3af41f790 and `data`=96'h2194261a9395e64dbed17115.
  - Expect exactly one `work_valid` pulse and no `frame_err`.
- **Bad checksum.** Send the same frame with checksum 0x1D. Expect one `frame_err` pulse, no `work_valid`, and outputs still equal to the previous good work.
- **Junk before header.** Send 0x00, 0xAA, 0xFF, then the good frame. Expect the junk ignored with no `frame_err`, then one `work_valid` carrying the values above.
- **Timeout.** With `TIMEOUT_CYCLES`=16, send the header plus 10 payload bytes, then idle 16 cycles.
  - Expect one `frame_err` and the FSM back in IDLE.
  - A following good frame must then load correctly.
- **Reset mid-frame and byte/reset collision.** Assert `reset` for 1 cycle after 20 payload bytes, with `rx_valid`=1 in that same cycle.
  - Expect all outputs 0, no pulses, and the byte dropped.
  - The next good frame must load normally.
- **Back-to-back frames.** Send two good frames with no gap, the second using an all-0x01 payload and checksum 0x00.
  - Expect two `work_valid` pulses 46 cycles apart.
  - Final `midstate` is all bytes 0x01, and `data`=96'h010101010101010101010101.

Source files
------------

// File: rtl/work_loader.sv
// Work loader: frames HEADER + 44 payload bytes + XOR checksum from a byte stream
// and publishes midstate/data to the mining core on a good frame only.
module work_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  HEADER         = 8'h55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [255:0] midstate,
    output logic [95:0]  data,
    output logic         work_valid,
    output logic         frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    localparam logic [5:0] LAST_BYTE = 6'd43;

    state_t         state_reg, state_next;
    logic [5:0]     cnt_reg, cnt_next;
    logic [7:0]     xor_reg, xor_next;
    logic [31:0]    gap_reg, gap_next;
    logic [351:0]   shadow_reg, shadow_next;
    logic [255:0]   midstate_reg, midstate_next;
    logic [95:0]    data_reg, data_next;
    logic           work_valid_reg, work_valid_next;
    logic           frame_err_reg, frame_err_next;
    logic           timeout_hit;

    // Fires only on the cycle the idle gap completes; a byte in that cycle wins.
    assign timeout_hit = (state_reg != S_IDLE) && !rx_valid
                         && (gap_reg == TIMEOUT_CYCLES - 1);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        xor_next        = xor_reg;
        gap_next        = gap_reg;
        shadow_next     = shadow_reg;
        midstate_next   = midstate_reg;
        data_next       = data_reg;
        work_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                gap_next = '0;
                if (rx_valid && rx_data == HEADER) begin
                    state_next = S_PAYLOAD;
                    cnt_next   = '0;
                    xor_next   = '0;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    shadow_next = {shadow_reg[343:0], rx_data};
                    xor_next    = xor_reg ^ rx_data;
                    cnt_next    = cnt_reg + 6'd1;
                    gap_next    = '0;
                    if (cnt_reg == LAST_BYTE) begin
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == xor_reg) begin
                        midstate_next   = shadow_reg[351:96];
                        data_next       = shadow_reg[95:0];
                        work_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    xor_next   = '0;
                    gap_next   = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_next     = S_IDLE;
            cnt_next       = '0;
            xor_next       = '0;
            gap_next       = '0;
            frame_err_next = 1'b1;
        end else if (state_reg != S_IDLE && !rx_valid && gap_reg != '1) begin
            gap_next = gap_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            xor_reg        <= '0;
            gap_reg        <= '0;
            shadow_reg     <= '0;
            midstate_reg   <= '0;
            data_reg       <= '0;
            work_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            xor_reg        <= xor_next;
            gap_reg        <= gap_next;
            shadow_reg     <= shadow_next;
            midstate_reg   <= midstate_next;
            data_reg       <= data_next;
            work_valid_reg <= work_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign midstate   = midstate_reg;
    assign data       = data_reg;
    assign work_valid = work_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule
